// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Bundles the byte-receive handshake and the instruction-memory write port
//   of the image loader.
//
//   rx_data  [7:0]  image byte from the host/UART receiver
//   rx_valid        rx_data valid
//   rx_ready        loader accepts the byte (transfer on rx_valid && rx_ready)
//   wr_en           instruction-memory write strobe, one cycle per word
//   wr_addr [31:0]  byte address of the write
//   wr_data [31:0]  little-endian assembled word
//
//   slave  : the loader itself
//   master : the byte source / memory side that talks to the loader
// ---------------------------------------------------------------------------
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Receives a byte-serial program image (4-byte little-endian word count N,
//   then 4*N payload bytes), assembles little-endian 32-bit words and writes
//   them to instruction memory starting at BASE_ADDR. The CPU is held in
//   reset (cpu_hold=1) until the image has been completely written.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, a trailing byte equal to the XOR of all payload bytes
//     follows the payload; a mismatch sends the loader to the error state.
//
//   Ports
//     clk           system clock, rising edge
//     rst_n         asynchronous active-low reset
//     bus           imem_loader_if.slave (rx handshake + memory write port)
//     load_start    one-cycle pulse, restarts a load from DONE or ERR
//     cpu_hold      1 = keep the CPU in reset
//     words_loaded  number of write strobes issued in the current load
//     load_error    high while in the error state (sticky until load_start)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_loader_if.slave          bus,
    input  logic                  load_start,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH-2:0] words_loaded,
    output logic                  load_error
);

    localparam int unsigned MAX_WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam int          CW        = ADDR_WIDTH - 1;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM = 3'd2,
`endif
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [31:0]    shift_q, shift_d;
    logic [CW-1:0]  len_q, len_d;
    logic [CW-1:0]  word_idx_q, word_idx_d;
    logic [CW-1:0]  words_q, words_d;
    logic           wr_en_q, wr_en_d;
    logic [31:0]    wr_addr_q, wr_addr_d;
    logic [31:0]    wr_data_q, wr_data_d;
    logic           cpu_hold_q, cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]     csum_q, csum_d;
`endif

    logic           rx_ready;
    logic           accept;
    logic [31:0]    shifted;
    logic [CW-1:0]  idx_next;

    // Bytes arrive LSB first, so shifting right leaves the first byte in [7:0].
    assign shifted  = {bus.rx_data, shift_q[31:8]};
    assign idx_next = word_idx_q + CW'(1);

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_LEN, S_DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:        rx_ready = 1'b1;
`endif
            default:       rx_ready = 1'b0;
        endcase
    end

    assign accept = bus.rx_valid && rx_ready;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        words_d    = words_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_hold_d = cpu_hold_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        // words_loaded trails the strobe by one cycle; a restart below wins.
        if (wr_en_q) begin
            words_d = words_q + CW'(1);
        end

        case (state_q)
            S_LEN: begin
                cpu_hold_d = 1'b1;
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = shifted;
                    if (byte_cnt_q == 2'd3) begin
                        if (shifted == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d    = S_DONE;
                            cpu_hold_d = 1'b0;
`endif
                        end else if (shifted > 32'(MAX_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            len_d   = shifted[CW-1:0];
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                cpu_hold_d = 1'b1;
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = shifted;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Write strobe lands exactly one cycle after byte 4.
                        wr_en_d    = 1'b1;
                        wr_data_d  = shifted;
                        wr_addr_d  = BASE_ADDR + (32'(word_idx_q) << 2);
                        word_idx_d = idx_next;
                        if (idx_next == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            // cpu_hold drops from DONE, i.e. after the strobe.
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                cpu_hold_d = 1'b1;
                if (accept) begin
                    if (bus.rx_data == csum_q) begin
                        state_d    = S_DONE;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
`endif

            S_DONE: begin
                cpu_hold_d = 1'b0;
            end

            S_ERR: begin
                cpu_hold_d = 1'b1;
            end

            default: begin
                state_d = S_LEN;
            end
        endcase

        if (load_start && (state_q == S_DONE || state_q == S_ERR)) begin
            state_d    = S_LEN;
            byte_cnt_d = 2'd0;
            shift_d    = 32'd0;
            len_d      = '0;
            word_idx_d = '0;
            words_d    = '0;
            wr_addr_d  = BASE_ADDR;
            cpu_hold_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LEN;
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
            len_q      <= '0;
            word_idx_q <= '0;
            words_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= 32'd0;
            cpu_hold_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            words_q    <= words_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign cpu_hold      = cpu_hold_q;
    assign words_loaded  = words_q;
    assign load_error    = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: stimulus pushes expected memory writes into a
// queue; an independent monitor pops and compares on every write strobe.
module tb_imem_loader;

    localparam int          AW   = 12;
    localparam int          MAXW = 1024;
    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk;
    logic rst_n;
    logic load_start;
    logic cpu_hold;
    logic [AW-2:0] words_loaded;
    logic load_error;

    imem_loader_if bus();

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .load_start   (load_start),
        .cpu_hold     (cpu_hold),
        .words_loaded (words_loaded),
        .load_error   (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  passed = 0;
    int  exp_idx = 0;
    logic [7:0] tb_csum = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", bus.wr_addr, 32'hFFFFFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", bus.wr_addr, e.addr);
                check("write_data", bus.wr_data, e.data);
                check("hold_during_write", {31'd0, cpu_hold}, 32'd1);
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (bus.rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.rx_ready !== 1'b1) begin
            check("rx_ready_timeout", {31'd0, bus.rx_ready}, 32'd1);
        end else begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = b;
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic gap(input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) @(negedge clk);
    endtask

    task automatic send_len(input logic [31:0] n, input int gap_max);
        tb_csum = 8'd0;
        exp_idx = 0;
        for (int i = 0; i < 4; i++) begin
            gap(gap_max);
            send_byte(n[8*i +: 8]);
        end
    endtask

    task automatic send_payload(input logic [31:0] w, input int gap_max);
        wr_t e;
        e.addr = BASE + 32'(exp_idx) * 32'd4;
        e.data = w;
        exp_q.push_back(e);
        exp_idx++;
        for (int i = 0; i < 4; i++) begin
            gap(gap_max);
            tb_csum = tb_csum ^ w[8*i +: 8];
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_csum);
`endif
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},     {31'd0, bus.rx_ready}, 32'd1);
        check({tag, "_wr_en"},        {31'd0, bus.wr_en},    32'd0);
        check({tag, "_wr_addr"},      bus.wr_addr,           BASE);
        check({tag, "_wr_data"},      bus.wr_data,           32'd0);
        check({tag, "_cpu_hold"},     {31'd0, cpu_hold},     32'd1);
        check({tag, "_words_loaded"}, 32'(words_loaded),     32'd0);
        check({tag, "_load_error"},   {31'd0, load_error},   32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        load_start   = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word image, gap-free.
        send_len(32'd2, 0);
        send_payload(32'h00000013, 0);
        send_payload(32'h00100093, 0);
`ifdef LOADER_CHECKSUM_EN
        send_csum();
        check("n2_hold_after_csum", {31'd0, cpu_hold}, 32'd0);
`else
        check("n2_hold_at_last_write", {31'd0, cpu_hold}, 32'd1);
        @(negedge clk);
        check("n2_hold_falls", {31'd0, cpu_hold}, 32'd0);
`endif
        check("n2_words_loaded", 32'(words_loaded), 32'd2);
        check("n2_rx_ready_done", {31'd0, bus.rx_ready}, 32'd0);

        pulse_start();
        check("restart_hold", {31'd0, cpu_hold}, 32'd1);
        check("restart_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        check("restart_words", 32'(words_loaded), 32'd0);

        // Empty image.
        send_len(32'd0, 0);
        send_csum();
        check("n0_hold", {31'd0, cpu_hold}, 32'd0);
        check("n0_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("n0_words", 32'(words_loaded), 32'd0);
        pulse_start();

        // Oversize count.
        send_len(32'h00000401, 0);
        check("over_error", {31'd0, load_error}, 32'd1);
        check("over_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("over_hold", {31'd0, cpu_hold}, 32'd1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hFF;
        repeat (3) @(negedge clk);
        bus.rx_valid = 1'b0;
        check("over_ignore_rx_error", {31'd0, load_error}, 32'd1);
        check("over_ignore_rx_words", 32'(words_loaded), 32'd0);
        pulse_start();
        check("over_clear_error", {31'd0, load_error}, 32'd0);
        check("over_clear_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        // Largest legal image fills the whole memory.
        send_len(32'(MAXW), 0);
        for (int i = 0; i < MAXW; i++) send_payload(32'hA5000000 | 32'(i), 0);
        send_csum();
        repeat (2) @(negedge clk);
        check("max_words_loaded", 32'(words_loaded), 32'(MAXW));
        check("max_hold", {31'd0, cpu_hold}, 32'd0);
        check("max_error", {31'd0, load_error}, 32'd0);
        pulse_start();

        // Same two-word image with random rx_valid gaps.
        send_len(32'd2, 3);
        send_payload(32'h00000013, 3);
        send_payload(32'h00100093, 3);
        send_csum();
        repeat (2) @(negedge clk);
        check("gap_words_loaded", 32'(words_loaded), 32'd2);
        check("gap_hold", {31'd0, cpu_hold}, 32'd0);
        pulse_start();

        // Reset after six payload bytes, then a fresh one-word load.
        send_len(32'd2, 0);
        send_payload(32'h11223344, 0);
        send_byte(8'h55);
        send_byte(8'h66);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_len(32'd1, 0);
        send_payload(32'h00000013, 0);
        send_csum();
        repeat (2) @(negedge clk);
        check("fresh_words_loaded", 32'(words_loaded), 32'd1);
        check("fresh_hold", {31'd0, cpu_hold}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        send_len(32'd1, 0);
        send_payload(32'h00000013, 0);
        send_byte(8'h14);
        @(negedge clk);
        check("bad_csum_error", {31'd0, load_error}, 32'd1);
        check("bad_csum_hold", {31'd0, cpu_hold}, 32'd1);
        pulse_start();
        check("bad_csum_clear", {31'd0, load_error}, 32'd0);
`endif

        repeat (5) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
